// File: rtl/mux4_scanner_if.sv
// mux4_scanner_if: control, mux select/sample and valid/ready word bus of the scanner
interface mux4_scanner_if;
   logic       start;
   logic       cont;
   logic       z;
   logic [1:0] sel;
   logic       busy;
   logic [3:0] data_out;
   logic       data_valid;
   logic       data_ready;
   modport master (output start, cont, z, data_ready, input sel, busy, data_out, data_valid);
   modport slave (input start, cont, z, data_ready, output sel, busy, data_out, data_valid);
endinterface

// File: rtl/mux4_scanner.sv
// mux4_scanner: steps mux4 sel through channels 0..3, samples z after DWELL cycles each,
// and offers the 4-bit word over valid/ready, single-shot or continuous.
module mux4_scanner #(
   parameter int DWELL = 2
) (
   input logic clk,
   input logic rst,
   mux4_scanner_if.slave bus
);
   localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0] sel_n;
   logic [3:0] word, word_n, dout_n;
   logic dv_n, busy_n, last;
   assign last = cnt == CW'(DWELL - 1);
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      sel_n = bus.sel;
      word_n = word;
      dout_n = bus.data_out;
      dv_n = bus.data_valid;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = SCAN;
               sel_n = '0;
               cnt_n = '0;
               word_n = '0;
            end
         end
         SCAN: begin
            cnt_n = last ? '0 : cnt + CW'(1);
            if (last) begin
               word_n[bus.sel] = bus.z;
               if (bus.sel == 2'd3) begin
                  dout_n = {bus.z, word[2:0]};
                  dv_n = 1'b1;
                  state_n = HOLD;
               end else begin
                  sel_n = bus.sel + 2'd1;
               end
            end
         end
         HOLD: begin
            if (bus.data_ready) begin
               dv_n = 1'b0;
               sel_n = '0;
               cnt_n = '0;
               word_n = '0;
               state_n = bus.cont ? SCAN : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = state_n != IDLE;
   end
   // busy is registered from the next state so every output comes straight from a flop
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         word <= '0;
         bus.sel <= '0;
         bus.busy <= 1'b0;
         bus.data_out <= '0;
         bus.data_valid <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         word <= word_n;
         bus.sel <= sel_n;
         bus.busy <= busy_n;
         bus.data_out <= dout_n;
         bus.data_valid <= dv_n;
      end
   end
endmodule

// File: tb/tb_mux4_scanner.sv
// tb_mux4_scanner: directed checks of the scanner at DWELL=2 (dut_a) and DWELL=1 (dut_b),
// with a behavioural mux4 selecting from d2/d1 by the DUT's sel.
module tb_mux4_scanner;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] d2 = '0;
   logic [3:0] d1 = '0;
   int checks = 0;
   int errors = 0;
   mux4_scanner_if a ();
   mux4_scanner_if b ();
   assign a.z = d2[a.sel];
   assign b.z = d1[b.sel];
   mux4_scanner #(.DWELL(2)) dut_a (.clk(clk), .rst(rst), .bus(a));
   mux4_scanner #(.DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(b));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit seen;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if ({a.sel, a.busy, a.data_valid, a.data_out} !== 8'h00) begin errors++; $display("FAIL reset_a: got %b want 00000000", {a.sel, a.busy, a.data_valid, a.data_out}); end
      checks++; if ({b.sel, b.busy, b.data_valid, b.data_out} !== 8'h00) begin errors++; $display("FAIL reset_b: got %b want 00000000", {b.sel, b.busy, b.data_valid, b.data_out}); end
      d2 = 4'b1111;
      a.start = 1'b1;
      tick();
      a.start = 1'b0;
      tick();
      tick();
      tick();
      checks++; if (a.busy !== 1'b1 || a.sel !== 2'd1) begin errors++; $display("FAIL midscan: busy=%b sel=%0d want busy=1 sel=1", a.busy, a.sel); end
      rst = 1'b1;
      tick();
      checks++; if ({a.sel, a.busy, a.data_valid, a.data_out} !== 8'h00) begin errors++; $display("FAIL abort_reset: got %b want 00000000", {a.sel, a.busy, a.data_valid, a.data_out}); end
      tick();
      rst = 1'b0;
      checks++; if ({a.sel, a.busy, a.data_valid, a.data_out} !== 8'h00) begin errors++; $display("FAIL after_reset: got %b want 00000000", {a.sel, a.busy, a.data_valid, a.data_out}); end
      d2 = 4'b0011;
      a.start = 1'b1;
      tick();
      a.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (a.data_valid) seen = 1'b1;
         else tick();
      end
      checks++; if (!seen || a.data_out !== 4'b0011) begin errors++; $display("FAIL rescan: valid=%b data=%b want valid=1 data=0011", seen, a.data_out); end
      tick();
      tick();
   endtask

   task automatic test_single();
      d2 = 4'b1010;
      a.start = 1'b1;
      tick();
      a.start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++; if (a.sel !== 2'(k / 2) || a.busy !== 1'b1 || a.data_valid !== 1'b0) begin errors++; $display("FAIL single_seq%0d: sel=%0d busy=%b valid=%b want sel=%0d busy=1 valid=0", k, a.sel, a.busy, a.data_valid, k / 2); end
         tick();
      end
      checks++; if (a.data_valid !== 1'b1 || a.data_out !== 4'b1010 || a.sel !== 2'd3) begin errors++; $display("FAIL single_word: valid=%b data=%b sel=%0d want 1 1010 3", a.data_valid, a.data_out, a.sel); end
      tick();
      checks++; if (a.data_valid !== 1'b0 || a.busy !== 1'b0 || a.sel !== 2'd0) begin errors++; $display("FAIL single_idle: valid=%b busy=%b sel=%0d want 0 0 0", a.data_valid, a.busy, a.sel); end
   endtask

   task automatic test_backpressure();
      a.data_ready = 1'b0;
      d2 = 4'b1010;
      a.start = 1'b1;
      tick();
      a.start = 1'b0;
      repeat (8) tick();
      d2 = 4'b0101;
      for (int k = 0; k < 5; k++) begin
         checks++; if (a.data_valid !== 1'b1 || a.data_out !== 4'b1010 || a.sel !== 2'd3 || a.busy !== 1'b1) begin errors++; $display("FAIL hold%0d: valid=%b data=%b sel=%0d busy=%b want 1 1010 3 1", k, a.data_valid, a.data_out, a.sel, a.busy); end
         tick();
      end
      a.data_ready = 1'b1;
      tick();
      checks++; if (a.data_valid !== 1'b0 || a.busy !== 1'b0 || a.data_out !== 4'b1010) begin errors++; $display("FAIL bp_accept: valid=%b busy=%b data=%b want 0 0 1010", a.data_valid, a.busy, a.data_out); end
   endtask

   task automatic test_continuous();
      d1 = 4'b1111;
      b.cont = 1'b1;
      b.data_ready = 1'b1;
      b.start = 1'b1;
      tick();
      b.start = 1'b0;
      repeat (3) tick();
      checks++; if (b.data_valid !== 1'b0) begin errors++; $display("FAIL cont_early: valid=%b want 0", b.data_valid); end
      tick();
      checks++; if (b.data_valid !== 1'b1 || b.data_out !== 4'b1111) begin errors++; $display("FAIL cont_word1: valid=%b data=%b want 1 1111", b.data_valid, b.data_out); end
      d1 = 4'b0001;
      tick();
      checks++; if (b.data_valid !== 1'b0 || b.busy !== 1'b1 || b.sel !== 2'd0) begin errors++; $display("FAIL cont_restart: valid=%b busy=%b sel=%0d want 0 1 0", b.data_valid, b.busy, b.sel); end
      b.cont = 1'b0;
      for (int k = 1; k < 4; k++) begin
         tick();
         checks++; if (b.data_valid !== 1'b0 || b.sel !== 2'(k)) begin errors++; $display("FAIL cont_gap%0d: valid=%b sel=%0d want 0 %0d", k, b.data_valid, b.sel, k); end
      end
      tick();
      checks++; if (b.data_valid !== 1'b1 || b.data_out !== 4'b0001) begin errors++; $display("FAIL cont_word2: valid=%b data=%b want 1 0001", b.data_valid, b.data_out); end
      tick();
      checks++; if (b.data_valid !== 1'b0 || b.busy !== 1'b0) begin errors++; $display("FAIL cont_stop: valid=%b busy=%b want 0 0", b.data_valid, b.busy); end
   endtask

   task automatic test_ignored_start();
      int words;
      d2 = 4'b0110;
      a.cont = 1'b0;
      a.data_ready = 1'b1;
      a.start = 1'b1;
      tick();
      a.start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++; if (a.sel !== 2'(k / 2) || a.data_valid !== 1'b0) begin errors++; $display("FAIL ign_seq%0d: sel=%0d valid=%b want %0d 0", k, a.sel, a.data_valid, k / 2); end
         a.start = (k == 3);
         tick();
      end
      a.start = 1'b1;
      checks++; if (a.data_valid !== 1'b1 || a.data_out !== 4'b0110) begin errors++; $display("FAIL ign_word: valid=%b data=%b want 1 0110", a.data_valid, a.data_out); end
      tick();
      a.start = 1'b0;
      words = 0;
      for (int k = 0; k < 12; k++) begin
         if (a.data_valid || a.busy) words++;
         tick();
      end
      checks++; if (words !== 0) begin errors++; $display("FAIL ign_restart: active cycles=%0d want 0", words); end
   endtask

   task automatic test_dwell1();
      d1 = 4'b1000;
      b.cont = 1'b0;
      b.data_ready = 1'b1;
      b.start = 1'b1;
      tick();
      b.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++; if (b.sel !== 2'(k) || b.data_valid !== 1'b0) begin errors++; $display("FAIL d1_seq%0d: sel=%0d valid=%b want %0d 0", k, b.sel, b.data_valid, k); end
         tick();
      end
      checks++; if (b.data_valid !== 1'b1 || b.data_out !== 4'b1000) begin errors++; $display("FAIL d1_word: valid=%b data=%b want 1 1000", b.data_valid, b.data_out); end
      tick();
      checks++; if (b.busy !== 1'b0 || b.data_valid !== 1'b0) begin errors++; $display("FAIL d1_idle: busy=%b valid=%b want 0 0", b.busy, b.data_valid); end
   endtask

   initial begin
      a.start = 1'b0;
      a.cont = 1'b0;
      a.data_ready = 1'b1;
      b.start = 1'b0;
      b.cont = 1'b0;
      b.data_ready = 1'b1;
      #1;
      test_reset();
      test_single();
      test_backpressure();
      test_continuous();
      test_ignored_start();
      test_dwell1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mux4_scanner.md
# mux4_scanner

Scan controller that sits around the `mux4` selector. It drives `mux4`'s `sel` input through channels 0→3 and samples `mux4`'s output `z` after a programmable settle time per channel. It assembles the four samples into a 4-bit word and hands the word downstream over a valid/ready handshake. It supports single-shot scans on `start` and continuous back-to-back scans.

## Interface
Parameters:
- `DWELL`, default 2: cycles `sel` is held per channel before `z` is sampled. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one scan when idle; ignored while `busy`=1.
- `cont`  in  1  continuous mode; sampled at each handshake.
- `z`  in  1  output of `mux4`.
- `sel`  out  2  channel select to `mux4`.
- `busy`  out  1  scan or hold in progress.
- `data_out`  out  4  sampled word; bit i is `z` sampled while `sel`=i.
- `data_valid`  out  1  `data_out` is valid.
- `data_ready`  in  1  downstream accepts the word.

## Operation
- The state machine has three states: IDLE, SCAN, HOLD.
- Reset: state IDLE, `sel`=0, `busy`=0, `data_valid`=0, `data_out`=0, dwell counter=0.
- IDLE:
  - `start`=1 → SCAN, with `sel`=0, counter=0, working word cleared.
  - `busy`=0.
- SCAN:
  - `busy`=1.
  - The counter increments each cycle.
  - When counter==DWELL-1, `z` is captured into working-word bit `sel` and the counter resets to 0.
  - If `sel`==3 at that edge: the working word is copied to `data_out`, `data_valid`←1, and the state moves to HOLD. `sel` stays 3.
  - Otherwise `sel` increments.
- HOLD:
  - `busy`=1, `data_valid`=1.
  - `data_out` and `sel` are stable until the handshake.
  - Handshake is the cycle where `data_valid`=1 and `data_ready`=1. On that edge `data_valid`←0, then:
    - `cont`=1 → SCAN, with `sel`=0 and counter=0.
    - `cont`=0 → IDLE, with `sel`=0.
- `data_ready` is ignored outside HOLD. The word is never dropped or overwritten while unaccepted.
- `start` is ignored in SCAN and HOLD; it is not queued.
- `data_out` retains the last accepted word until the next scan completes.
- Counter width is clog2(DWELL), minimum 1 bit. DWELL=1 samples every cycle.
- Reset mid-scan or mid-hold aborts immediately to the reset values. The partial word is discarded.

## Timing
- Let the edge that accepts `start` be E0. `sel`=0 is visible after E0.
- `sel` changes on edges E0+k·DWELL, k=1..3.
- Channel i is sampled on edge E0+(i+1)·DWELL. `z` therefore has DWELL-1 full cycles of settle after each `sel` change, plus the sampling cycle.
- `data_valid` rises after edge E0+4·DWELL. Scan latency is 4·DWELL cycles.
- If `data_ready` is already high at that point, the handshake occurs at the next edge, so the minimum `data_valid` pulse is 1 cycle.
- Continuous-mode throughput is one word per 4·DWELL+1 cycles when `data_ready` is held high.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset: assert `rst` for 2 cycles mid-scan → all outputs zero on the next cycle and state IDLE. A subsequent `start` produces a full, correct scan.
- Single scan, DWELL=2, `mux4` inputs d3..d0=4'b1010, `data_ready`=1, `cont`=0:
  - `sel` sequence 0,0,1,1,2,2,3,3.
  - `data_valid` high after E0+8.
  - `data_out`=4'b1010.
  - Returns to IDLE with `busy`=0 one cycle later.
- Backpressure: `data_ready`=0 for 5 cycles after `data_valid`, and d0..d3 changed meanwhile to 4'b0101 → `data_out` stays 4'b1010 and `sel` stays 3. Handshake completes on the first `data_ready`=1.
- Continuous: `cont`=1, `data_ready`=1, DWELL=1, inputs 4'b1111 then 4'b0001 → consecutive words 4'b1111 and 4'b0001, with `data_valid` pulses 5 cycles apart.
- Ignored start: pulse `start` during SCAN and during HOLD → no restart. `sel` sequence is unchanged and exactly one word is produced.
- DWELL=1 boundary: inputs 4'b1000 → word 4'b1000, with `data_valid` after E0+4.
